// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file constants and clear-sweep FSM state type
package rv_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    typedef enum logic {CLEAR, READY} rf_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits with issue-over-writeback priority; REGFILE_BYPASS_EN forwards same-cycle writeback
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_ena,
    input  logic [AW-1:0]     i_clr_reg,
    input  logic              i_set_ena,
    input  logic [AW-1:0]     i_set_reg,
    input  logic              i_busy,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_pend
);
    logic [NREGS-1:0] r_pend;
    // writeback clears, issue sets; issue is applied last so it wins on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            if (i_clr_ena) r_pend[i_clr_reg] <= 1'b0;
            if (i_set_ena) r_pend[i_set_reg] <= 1'b1;
        end
    end
    for (genvar p = 0; p < NRD; p++) begin : g_pend
        logic [AW-1:0] w_a;
        assign w_a = i_rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign o_rd_pend[p] = i_busy ? 1'b0
                            : (i_clr_ena && i_clr_reg == w_a) ? (i_set_ena && i_set_reg == w_a)
                            : r_pend[w_a];
`else
        assign o_rd_pend[p] = i_busy ? 1'b0 : r_pend[w_a];
`endif
    end
endmodule

// File: rtl/banco_registros.sv
// banco_registros: RV32 integer register file with post-reset clear sweep, busy flag and pending-write scoreboard; REGFILE_BYPASS_EN enables write-through forwarding
module banco_registros
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_ena,
    input  logic [AW-1:0]       wr_reg,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_ena,
    input  logic [AW-1:0]       iss_reg,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    output logic                busy
);
    logic [XLEN-1:0] r_regs [1:NREGS-1];
    rf_state_t       r_state;
    logic [AW-1:0]   r_idx;
    logic            w_busy, w_wr, w_iss;
    assign w_busy = r_state == CLEAR;
    assign busy   = w_busy;
    assign w_wr   = wr_ena && wr_reg != '0 && !w_busy;
    assign w_iss  = iss_ena && iss_reg != '0 && !w_busy;
    // clear sweep walks idx 1..NREGS-1, stopping on the last register so idx never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_idx   <= AW'(1);
        end else if (r_state == CLEAR) begin
            if (r_idx == AW'(NREGS - 1)) r_state <= READY;
            else r_idx <= r_idx + AW'(1);
        end
    end
    // storage: sweep zeroes one register per cycle, otherwise accept writeback
    always_ff @(posedge clk) begin
        if (w_busy) r_regs[r_idx] <= '0;
        else if (w_wr) r_regs[wr_reg] <= wr_data;
    end
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_q;
        assign w_a = rd_addr[p*AW +: AW];
        assign w_q = w_a == '0 ? '0 : r_regs[w_a];
`ifdef REGFILE_BYPASS_EN
        assign rd_data[p*XLEN +: XLEN] = w_busy ? '0 : (w_wr && wr_reg == w_a) ? wr_data : w_q;
`else
        assign rd_data[p*XLEN +: XLEN] = w_busy ? '0 : w_q;
`endif
    end
    rf_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_clr_ena (w_wr),
        .i_clr_reg (wr_reg),
        .i_set_ena (w_iss),
        .i_set_reg (iss_reg),
        .i_busy    (w_busy),
        .i_rd_addr (rd_addr),
        .o_rd_pend (rd_pend)
    );
endmodule

// File: tb/tb_banco_registros.sv
// tb_banco_registros: directed and random checks of banco_registros against an array-based model; follows REGFILE_BYPASS_EN
module tb_banco_registros;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic                clk = 1'b0;
    logic                rst, wr_ena, iss_ena;
    logic [AW-1:0]       wr_reg, iss_reg;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pend;
    logic                busy;
    logic [31:0] m_reg [NREGS];
    bit          m_pend [NREGS];
    int          m_left = NREGS - 1;
    int          errors = 0;
    int          checks = 0;
    int          n;

    banco_registros dut (
        .clk     (clk),
        .rst     (rst),
        .wr_ena  (wr_ena),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .iss_ena (iss_ena),
        .iss_reg (iss_reg),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_pend (rd_pend),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (rst) begin
            foreach (m_reg[i]) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_left = NREGS - 1;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (wr_ena && wr_reg != 0) begin
                m_reg[wr_reg]  = wr_data;
                m_pend[wr_reg] = 1'b0;
            end
            if (iss_ena && iss_reg != 0) m_pend[iss_reg] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] a;
        logic [31:0]   ed;
        bit            ep, fwd;
        #1;
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(m_left > 0));
        for (int p = 0; p < NRD; p++) begin
            a   = rd_addr[p*AW +: AW];
            fwd = BYP && wr_ena && wr_reg == a;
            ed  = (m_left > 0 || a == 0) ? 32'h0 : fwd ? wr_data : m_reg[a];
            ep  = (m_left > 0 || a == 0) ? 1'b0 : fwd ? (iss_ena && iss_reg == a) : m_pend[a];
            chk($sformatf("%s.data%0d", tag, p), rd_data[p*XLEN +: XLEN], ed);
            chk($sformatf("%s.pend%0d", tag, p), 32'(rd_pend[p]), 32'(ep));
        end
    endtask

    initial begin
        rst = 1'b1; wr_ena = 1'b0; iss_ena = 1'b0;
        wr_reg = '0; iss_reg = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        check_all("reset");
        chk("reset_busy", 32'(busy), 32'd1);
        rst = 1'b0; wr_ena = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        tick();
        wr_ena = 1'b0;
        check_all("sweep");
        n = 1;
        while (busy === 1'b1 && n < 100) begin
            tick();
            check_all("sweep");
            n++;
        end
        chk("sweep_len", 32'(n), 32'(NREGS - 1));
        chk("x5_cleared", rd_data[31:0], 32'h0);

        wr_ena = 1'b1; wr_reg = 5'd7; wr_data = 32'h12345678;
        tick();
        wr_reg = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_ena = 1'b0; rd_addr = {5'd0, 5'd7};
        check_all("rw");
        chk("rw_x7", rd_data[31:0], 32'h12345678);
        chk("rw_x0", rd_data[63:32], 32'h0);

        iss_ena = 1'b1; iss_reg = 5'd3; rd_addr = {5'd3, 5'd3};
        tick();
        iss_ena = 1'b0;
        check_all("sb1");
        chk("sb_pend1", 32'(rd_pend[0]), 32'd1);
        tick();
        check_all("sb2");
        chk("sb_pend2", 32'(rd_pend[0]), 32'd1);
        wr_ena = 1'b1; wr_reg = 5'd3; wr_data = 32'hA5;
        tick();
        wr_ena = 1'b0;
        check_all("sb3");
        chk("sb_pend_clr", 32'(rd_pend[0]), 32'd0);
        chk("sb_data", rd_data[31:0], 32'hA5);

        iss_ena = 1'b1; iss_reg = 5'd9; wr_ena = 1'b1; wr_reg = 5'd9; wr_data = 32'h55;
        tick();
        iss_ena = 1'b0; wr_ena = 1'b0; rd_addr = {5'd9, 5'd9};
        check_all("coll");
        chk("coll_data", rd_data[31:0], 32'h55);
        chk("coll_pend", 32'(rd_pend[1]), 32'd1);

        wr_ena = 1'b1; wr_reg = 5'd4; wr_data = 32'h1111;
        tick();
        wr_data = 32'hCAFE; rd_addr = {5'd4, 5'd0};
        check_all("byp");
        chk("byp_port1", rd_data[63:32], BYP ? 32'hCAFE : 32'h1111);
        tick();
        wr_ena = 1'b0;
        check_all("byp_after");
        chk("byp_after_port1", rd_data[63:32], 32'hCAFE);

        iss_ena = 1'b1; iss_reg = 5'd12;
        tick();
        iss_ena = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_all("mid");
        end
        rst = 1'b1;
        tick();
        check_all("mid_rst");
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            check_all("resweep");
            n++;
        end
        chk("resweep_len", 32'(n), 32'(NREGS - 1));
        for (int a = 0; a < NREGS; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            check_all("scan");
            chk($sformatf("scan_pend%0d", a), 32'(rd_pend), 32'd0);
        end

        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom % 80) == 0;
            wr_ena  = $urandom % 2 == 0;
            wr_reg  = 5'($urandom % 8);
            wr_data = $urandom;
            iss_ena = $urandom % 3 == 0;
            iss_reg = ($urandom % 4 == 0) ? wr_reg : 5'($urandom % 8);
            rd_addr[4:0] = ($urandom % 3 == 0) ? wr_reg : 5'($urandom % 8);
            rd_addr[9:5] = ($urandom % 3 == 0) ? iss_reg : 5'($urandom % 8);
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/banco_registros.md
# banco_registros

Parametrised integer register file for the RV32 core. It is the generalised successor of the fixed two-read/one-write bank, with configurable width, depth and read-port count. It adds a sequential clear sweep after reset with a `busy` indication, plus a per-register pending-write scoreboard for hazard detection. It sits in decode: read ports feed operand muxes, the write port is driven by writeback, and the issue port is driven by the instruction issue logic.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers; power of two, ≥ 2.
- `NRD`, 2, number of read ports, 1–4.
- `AW`, `$clog2(NREGS)`, address width; derived, never overridden.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_ena`  in  1  writeback enable.
- `wr_reg`  in  AW  writeback destination address.
- `wr_data`  in  XLEN  writeback data.
- `iss_ena`  in  1  issue of an instruction that will later write `iss_reg`.
- `iss_reg`  in  AW  destination address of the issued instruction.
- `rd_addr`  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW].
- `rd_data`  out  NRD*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
- `rd_pend`  out  NRD  port p: the addressed register has an outstanding write.
- `busy`  out  1  clear sweep in progress; writes and issues are not accepted.

## Operation
- Register x0 reads 0, is never pending, and ignores writes and issues. It needs no storage.
- Reads are combinational: `rd_data[p] = REG[rd_addr[p]]` and `rd_pend[p] = pend[rd_addr[p]]`.
- While `busy` = 1, every `rd_data` reads 0 and every `rd_pend` reads 0.
- Write: if `wr_ena`, `wr_reg` ≠ 0 and `busy` = 0, then `REG[wr_reg]` ← `wr_data` and `pend[wr_reg]` ← 0.
- Issue: if `iss_ena`, `iss_reg` ≠ 0 and `busy` = 0, then `pend[iss_reg]` ← 1.
- Write and issue to the same register in the same cycle: the data is written and `pend` ends at 1 (issue wins).
- Write and issue to different registers in the same cycle: both take effect.
- FSM states:
  - CLEAR: `busy` = 1. `idx` counts from 1 to NREGS−1 and zeroes `REG[idx]` each cycle.
  - READY: `busy` = 0.
- FSM transitions:
  - `rst` = 1 forces CLEAR with `idx` = 1 and all `pend` bits = 0, held for as long as `rst` stays high.
  - In CLEAR with `rst` = 0, each edge clears `REG[idx]` and increments `idx`. The edge that clears `idx` = NREGS−1 moves the FSM to READY.
  - READY stays in READY until `rst`.
- Reset asserted mid-sweep restarts the sweep from `idx` = 1.
- `idx` is AW bits wide and is never allowed to wrap.

## Timing
- Reset values: `busy` = 1, `rd_data` = 0, `rd_pend` = 0, all `pend` bits = 0.
- `busy` falls exactly NREGS−1 rising edges after the first edge with `rst` = 0. With defaults, that is 31 edges.
- Write latency is one edge: data written at edge k is visible on `rd_data` after edge k.
- Issue latency is one edge: `rd_pend` rises after the issuing edge and falls after the matching write edge.
- No combinational path from `wr_*` or `iss_*` to the outputs, except the bypass path (see Configuration).

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through forwarding is enabled.
  - If `wr_ena`, `busy` = 0 and `wr_reg` = `rd_addr[p]` ≠ 0, then `rd_data[p]` = `wr_data` in the same cycle.
  - `rd_pend[p]` reads 0 for that register unless `iss_ena` targets the same register in the same cycle, in which case it reads 1.
- `REGFILE_BYPASS_EN` undefined: reads show only registered state. Writeback becomes visible one cycle later, and the pipeline must stall one cycle for a read-after-write in the same cycle.

## Structure
- Shared package `rv_pkg`:
  - constants `XLEN_DEF` = 32 and `NREGS_DEF` = 32;
  - FSM state typedef `rf_state_t` {CLEAR, READY}.
- Sub-module `rf_scoreboard`: the NREGS pending bits, their set/clear priority, and the NRD pending-flag read muxes.
- The storage array, clear FSM and data read muxes stay in `banco_registros`.

## Test plan
- Reset and sweep: pulse `rst` for 2 cycles, write `REG[5]` to 0xDEADBEEF while busy. Required: `busy` = 1 for exactly 31 edges after release, and afterwards x5 reads 0.
- Basic read/write: write x7 = 0x12345678 and x0 = 0xFFFFFFFF, then read x7 and x0 on ports 0 and 1. Required: 0x12345678 and 0.
- Scoreboard: issue x3, then two cycles later write x3 = 0xA5. Required: `rd_pend` = 1 for exactly 2 cycles, then 0 with data 0xA5.
- Simultaneous issue and write: issue x9 and write x9 = 0x55 at the same edge. Required: data 0x55 and `rd_pend` = 1.
- Bypass: write x4 = 0xCAFE while port 1 reads x4 in the same cycle. Required: `rd_data[1]` = 0xCAFE with `REGFILE_BYPASS_EN` defined; the old value without it.
- Reset mid-sweep: assert `rst` at sweep index 10. Required: sweep restarts, `busy` lasts 31 more edges after release, and all `pend` bits = 0.
